// File: rtl/pipe_pkg.sv
// Shared pipeline bus definitions: widths, ALU one-hot indices, opcodes and
// the bit layout of the decode-to-execute bus.
package pipe_pkg;

  localparam int FS_TO_DS_W = 65;
  localparam int BR_W       = 33;
  localparam int DS_TO_ES_W = 152;
  // {valid, is_load, gr_we, dest[4:0], value[31:0]}
  localparam int ES_FWD_W   = 40;
  // {valid, gr_we, dest[4:0], value[31:0]}
  localparam int MS_FWD_W   = 39;

  localparam int ALU_ADD  = 0;
  localparam int ALU_SUB  = 1;
  localparam int ALU_SLT  = 2;
  localparam int ALU_SLTU = 3;
  localparam int ALU_AND  = 4;
  localparam int ALU_NOR  = 5;
  localparam int ALU_OR   = 6;
  localparam int ALU_XOR  = 7;
  localparam int ALU_SLL  = 8;
  localparam int ALU_SRL  = 9;
  localparam int ALU_SRA  = 10;
  localparam int ALU_LUI  = 11;

  localparam logic [16:0] OP17_ADD_W  = 17'h00020;
  localparam logic [16:0] OP17_SUB_W  = 17'h00022;
  localparam logic [16:0] OP17_SLT    = 17'h00024;
  localparam logic [16:0] OP17_SLTU   = 17'h00025;
  localparam logic [16:0] OP17_NOR    = 17'h00028;
  localparam logic [16:0] OP17_AND    = 17'h00029;
  localparam logic [16:0] OP17_OR     = 17'h0002A;
  localparam logic [16:0] OP17_XOR    = 17'h0002B;
  localparam logic [16:0] OP17_SLLI_W = 17'h00081;
  localparam logic [16:0] OP17_SRLI_W = 17'h00089;
  localparam logic [16:0] OP17_SRAI_W = 17'h00091;
  localparam logic [9:0]  OP10_ADDI_W = 10'h00A;
  localparam logic [9:0]  OP10_LD_W   = 10'h0A2;
  localparam logic [9:0]  OP10_ST_W   = 10'h0A6;
  localparam logic [5:0]  OP6_JIRL    = 6'h13;
  localparam logic [5:0]  OP6_B       = 6'h14;
  localparam logic [5:0]  OP6_BL      = 6'h15;
  localparam logic [5:0]  OP6_BEQ     = 6'h16;
  localparam logic [5:0]  OP6_BNE     = 6'h17;
  localparam logic [6:0]  OP7_LU12I_W = 7'h0A;

  localparam int DS_ALU_LSB  = 140;
  localparam int DS_RJ_LSB   = 108;
  localparam int DS_RKD_LSB  = 76;
  localparam int DS_IMM_LSB  = 44;
  localparam int DS_SRC1_PC  = 43;
  localparam int DS_SRC2_IMM = 42;
  localparam int DS_DEST_LSB = 37;
  localparam int DS_GR_WE    = 36;
  localparam int DS_MEM_WE   = 35;
  localparam int DS_RES_MEM  = 34;
  localparam int DS_EX_ADEF  = 33;
  localparam int DS_EX_INE   = 32;
  localparam int DS_PC_LSB   = 0;

  typedef struct packed {
    logic        valid;
    logic        is_load;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] value;
  } es_fwd_t;

  typedef struct packed {
    logic        valid;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] value;
  } ms_fwd_t;

endpackage

// File: rtl/regfile.sv
// 32x32 general register file: two asynchronous read ports, one synchronous
// write port, r0 reads as zero and ignores writes.
module regfile (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  raddr1_i,
  input  logic [4:0]  raddr2_i,
  output logic [31:0] rdata1_o,
  output logic [31:0] rdata2_o,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i
);

  logic [31:0] rf_q [32];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (we_i && (waddr_i != 5'd0)) begin
      rf_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata1_o = (raddr1_i == 5'd0) ? 32'd0 : rf_q[raddr1_i];
  assign rdata2_o = (raddr2_i == 5'd0) ? 32'd0 : rf_q[raddr2_i];

endmodule

// File: rtl/id_stage.sv
// LoongArch32 decode stage: holds one fetched instruction, decodes it, reads
// forwarded operands, resolves branches and stalls on load-use hazards.
module id_stage
  import pipe_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fs_to_ds_valid,
  input  logic [FS_TO_DS_W-1:0] fs_to_ds_bus,
  output logic                  ds_allowin,
  output logic [BR_W-1:0]       br_collect,
  input  logic                  es_allowin,
  output logic                  ds_to_es_valid,
  output logic [DS_TO_ES_W-1:0] ds_to_es_bus,
  input  logic [ES_FWD_W-1:0]   es_fwd,
  input  logic [MS_FWD_W-1:0]   ms_fwd,
  input  logic                  rf_we,
  input  logic [4:0]            rf_waddr,
  input  logic [31:0]           rf_wdata
);

  logic        ds_valid_q, ds_valid_d;
  logic        adef_q, adef_d;
  logic [31:0] inst_q, inst_d, pc_q, pc_d;

  logic        ds_ready_go, br_taken, br_cond;
  logic [31:0] br_target;
  es_fwd_t     es;
  ms_fwd_t     ms;

  assign es = es_fwd_t'(es_fwd);
  assign ms = ms_fwd_t'(ms_fwd);

  function automatic logic [31:0] fwd_value(input logic [4:0] idx, input es_fwd_t e,
                                            input ms_fwd_t m, input logic we,
                                            input logic [4:0] waddr, input logic [31:0] wdata,
                                            input logic [31:0] rdata);
    if (idx == 5'd0)                                return 32'd0;
    else if (e.valid && e.gr_we && e.dest == idx)   return e.value;
    else if (m.valid && m.gr_we && m.dest == idx)   return m.value;
    else if (we && waddr == idx)                    return wdata;
    else                                            return rdata;
  endfunction

  assign ds_allowin     = ~ds_valid_q | (ds_ready_go & es_allowin);
  assign ds_to_es_valid = ds_valid_q & ds_ready_go;

  always_comb begin
    ds_valid_d = ds_valid_q;
    adef_d     = adef_q;
    inst_d     = inst_q;
    pc_d       = pc_q;
    if (ds_allowin) begin
      // A taken branch leaving now squashes the wrong-path pc+4 fetch.
      ds_valid_d = fs_to_ds_valid & ~br_taken;
      adef_d     = fs_to_ds_bus[64];
      inst_d     = fs_to_ds_bus[63:32];
      pc_d       = fs_to_ds_bus[31:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ds_valid_q <= 1'b0;
      adef_q     <= 1'b0;
      inst_q     <= '0;
      pc_q       <= '0;
    end else begin
      ds_valid_q <= ds_valid_d;
      adef_q     <= adef_d;
      inst_q     <= inst_d;
      pc_q       <= pc_d;
    end
  end

  logic [16:0] op17;
  logic [9:0]  op10;
  logic [6:0]  op7;
  logic [5:0]  op6;
  logic [4:0]  rd, rj_idx, rkd_idx;

  assign op17   = inst_q[31:15];
  assign op10   = inst_q[31:22];
  assign op7    = inst_q[31:25];
  assign op6    = inst_q[31:26];
  assign rd     = inst_q[4:0];
  assign rj_idx = inst_q[9:5];

  logic i_add, i_sub, i_slt, i_sltu, i_nor, i_and, i_or, i_xor;
  logic i_slli, i_srli, i_srai, i_addi, i_ld, i_st, i_lu12i;
  logic i_jirl, i_b, i_bl, i_beq, i_bne;
  logic is_3r, is_shi, inst_known, writes_rd, uses_rj, uses_rkd;

  assign i_add   = (op17 == OP17_ADD_W);
  assign i_sub   = (op17 == OP17_SUB_W);
  assign i_slt   = (op17 == OP17_SLT);
  assign i_sltu  = (op17 == OP17_SLTU);
  assign i_nor   = (op17 == OP17_NOR);
  assign i_and   = (op17 == OP17_AND);
  assign i_or    = (op17 == OP17_OR);
  assign i_xor   = (op17 == OP17_XOR);
  assign i_slli  = (op17 == OP17_SLLI_W);
  assign i_srli  = (op17 == OP17_SRLI_W);
  assign i_srai  = (op17 == OP17_SRAI_W);
  assign i_addi  = (op10 == OP10_ADDI_W);
  assign i_ld    = (op10 == OP10_LD_W);
  assign i_st    = (op10 == OP10_ST_W);
  assign i_lu12i = (op7  == OP7_LU12I_W);
  assign i_jirl  = (op6  == OP6_JIRL);
  assign i_b     = (op6  == OP6_B);
  assign i_bl    = (op6  == OP6_BL);
  assign i_beq   = (op6  == OP6_BEQ);
  assign i_bne   = (op6  == OP6_BNE);

  assign is_3r      = i_add | i_sub | i_slt | i_sltu | i_nor | i_and | i_or | i_xor;
  assign is_shi     = i_slli | i_srli | i_srai;
  assign inst_known = is_3r | is_shi | i_addi | i_ld | i_st | i_lu12i |
                      i_jirl | i_b | i_bl | i_beq | i_bne;
  assign writes_rd  = is_3r | is_shi | i_addi | i_ld | i_lu12i | i_jirl | i_bl;
  assign uses_rj    = is_3r | is_shi | i_addi | i_ld | i_st | i_jirl | i_beq | i_bne;
  assign uses_rkd   = is_3r | i_st | i_beq | i_bne;
  assign rkd_idx    = (i_st | i_beq | i_bne) ? rd : inst_q[14:10];

  logic [11:0] alu_op;
  always_comb begin
    alu_op           = '0;
    alu_op[ALU_ADD]  = i_add | i_addi | i_ld | i_st | i_jirl | i_bl;
    alu_op[ALU_SUB]  = i_sub;
    alu_op[ALU_SLT]  = i_slt;
    alu_op[ALU_SLTU] = i_sltu;
    alu_op[ALU_AND]  = i_and;
    alu_op[ALU_NOR]  = i_nor;
    alu_op[ALU_OR]   = i_or;
    alu_op[ALU_XOR]  = i_xor;
    alu_op[ALU_SLL]  = i_slli;
    alu_op[ALU_SRL]  = i_srli;
    alu_op[ALU_SRA]  = i_srai;
    alu_op[ALU_LUI]  = i_lu12i;
  end

  logic [31:0] si12, offs16, offs26, imm;
  assign si12   = {{20{inst_q[21]}}, inst_q[21:10]};
  assign offs16 = {{14{inst_q[25]}}, inst_q[25:10], 2'b00};
  assign offs26 = {{4{inst_q[9]}}, inst_q[9:0], inst_q[25:10], 2'b00};

  always_comb begin
    imm = '0;
    if (is_shi)                     imm = {27'd0, inst_q[14:10]};
    else if (i_addi | i_ld | i_st)  imm = si12;
    else if (i_lu12i)               imm = {inst_q[24:5], 12'd0};
    else if (i_jirl | i_bl)         imm = 32'd4;
  end

  logic [4:0]  dest;
  logic        gr_we;
  assign dest  = i_bl ? 5'd1 : (writes_rd ? rd : 5'd0);
  assign gr_we = writes_rd & (dest != 5'd0);

  logic [31:0] rf_rdata1, rf_rdata2, rj_value, rkd_value;

  regfile u_regfile (
    .clk      (clk),
    .reset    (reset),
    .raddr1_i (rj_idx),
    .raddr2_i (rkd_idx),
    .rdata1_o (rf_rdata1),
    .rdata2_o (rf_rdata2),
    .we_i     (rf_we),
    .waddr_i  (rf_waddr),
    .wdata_i  (rf_wdata)
  );

  assign rj_value  = fwd_value(rj_idx,  es, ms, rf_we, rf_waddr, rf_wdata, rf_rdata1);
  assign rkd_value = fwd_value(rkd_idx, es, ms, rf_we, rf_waddr, rf_wdata, rf_rdata2);

  // A load in EX has no value yet; wait until it reaches MEM.
  assign ds_ready_go = ~(es.valid & es.is_load & es.gr_we & (es.dest != 5'd0) &
                         ((uses_rj & (es.dest == rj_idx)) | (uses_rkd & (es.dest == rkd_idx))));

  assign br_cond  = i_b | i_bl | i_jirl |
                    (i_beq & (rj_value == rkd_value)) | (i_bne & (rj_value != rkd_value));
  assign br_taken = ds_valid_q & ds_ready_go & ~adef_q & br_cond;

  always_comb begin
    br_target = pc_q + offs16;
    if (i_b | i_bl)   br_target = pc_q + offs26;
    else if (i_jirl)  br_target = rj_value + offs16;
  end

  assign br_collect = {br_taken, br_taken ? br_target : 32'd0};

  assign ds_to_es_bus = {alu_op, rj_value, rkd_value, imm,
                         i_jirl | i_bl,
                         is_shi | i_addi | i_ld | i_st | i_lu12i | i_jirl | i_bl,
                         dest, gr_we, i_st, i_ld, adef_q, ~inst_known, pc_q};

endmodule

// File: tb/tb_id_stage.sv
// Scenario bench for id_stage with a mnemonic-level reference model for the
// randomized decode/forwarding/branch sweep.
module tb_id_stage;

  logic         clk = 1'b0;
  logic         reset;
  logic         fs_to_ds_valid;
  logic [64:0]  fs_to_ds_bus;
  logic         ds_allowin;
  logic [32:0]  br_collect;
  logic         es_allowin;
  logic         ds_to_es_valid;
  logic [151:0] ds_to_es_bus;
  logic [39:0]  es_fwd;
  logic [38:0]  ms_fwd;
  logic         rf_we;
  logic [4:0]   rf_waddr;
  logic [31:0]  rf_wdata;

  int checks = 0;
  int errors = 0;

  logic        fs_adef;
  logic [31:0] fs_inst, fs_pc;
  logic        es_v, es_ld, es_we, ms_v, ms_we;
  logic [4:0]  es_dst, ms_dst;
  logic [31:0] es_val, ms_val;
  logic [31:0] regs [32];

  assign fs_to_ds_bus = {fs_adef, fs_inst, fs_pc};
  assign es_fwd       = {es_v, es_ld, es_we, es_dst, es_val};
  assign ms_fwd       = {ms_v, ms_we, ms_dst, ms_val};

  logic [11:0] o_alu;
  logic [31:0] o_rj, o_rkd, o_imm, o_pc;
  logic [4:0]  o_dest;
  logic        o_src1_pc, o_gr_we, o_adef, o_ine;
  assign o_alu     = ds_to_es_bus[151:140];
  assign o_rj      = ds_to_es_bus[139:108];
  assign o_rkd     = ds_to_es_bus[107:76];
  assign o_imm     = ds_to_es_bus[75:44];
  assign o_src1_pc = ds_to_es_bus[43];
  assign o_dest    = ds_to_es_bus[41:37];
  assign o_gr_we   = ds_to_es_bus[36];
  assign o_adef    = ds_to_es_bus[33];
  assign o_ine     = ds_to_es_bus[32];
  assign o_pc      = ds_to_es_bus[31:0];

  id_stage dut (
    .clk            (clk),
    .reset          (reset),
    .fs_to_ds_valid (fs_to_ds_valid),
    .fs_to_ds_bus   (fs_to_ds_bus),
    .ds_allowin     (ds_allowin),
    .br_collect     (br_collect),
    .es_allowin     (es_allowin),
    .ds_to_es_valid (ds_to_es_valid),
    .ds_to_es_bus   (ds_to_es_bus),
    .es_fwd         (es_fwd),
    .ms_fwd         (ms_fwd),
    .rf_we          (rf_we),
    .rf_waddr       (rf_waddr),
    .rf_wdata       (rf_wdata)
  );

  always #5 clk = ~clk;

  typedef enum int {M_ADD, M_SUB, M_SLT, M_SLTU, M_NOR, M_AND, M_OR, M_XOR,
                    M_SLLI, M_SRLI, M_SRAI, M_ADDI, M_LD, M_ST, M_LU12I,
                    M_JIRL, M_B, M_BL, M_BEQ, M_BNE, M_ILL} mnem_t;

  task automatic clear_fwd();
    es_v = 0; es_ld = 0; es_we = 0; es_dst = 0; es_val = 0;
    ms_v = 0; ms_we = 0; ms_dst = 0; ms_val = 0;
    rf_we = 0; rf_waddr = 0; rf_wdata = 0;
  endtask

  task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
    rf_we = 1; rf_waddr = a; rf_wdata = d;
    @(posedge clk); #1;
    rf_we = 0;
    if (a != 0) regs[a] = d;
  endtask

  task automatic issue(input logic [31:0] inst, input logic [31:0] pc, input logic adef);
    fs_to_ds_valid = 1; fs_inst = inst; fs_pc = pc; fs_adef = adef;
    @(posedge clk); #1;
    fs_to_ds_valid = 0;
  endtask

  task automatic drain();
    es_allowin = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1; es_allowin = 1; fs_to_ds_valid = 0;
    fs_inst = 0; fs_pc = 0; fs_adef = 0;
    clear_fwd();
    for (int i = 0; i < 32; i++) regs[i] = 0;
    #2;
    checks++; if (ds_allowin !== 1'b1) begin errors++; $display("FAIL reset_allowin: got %b want 1", ds_allowin); end
    checks++; if (ds_to_es_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", ds_to_es_valid); end
    checks++; if (br_collect !== 33'd0) begin errors++; $display("FAIL reset_br: got %h want 0", br_collect); end
    @(posedge clk); @(posedge clk); #1;
    reset = 0;
  endtask

  task automatic test_fwd_priority();
    wb_write(5'd4, 32'd5);
    issue(32'h00101083, 32'h1C000000, 1'b0);
    ms_v = 1; ms_we = 1; ms_dst = 4; ms_val = 6;
    es_v = 1; es_we = 1; es_dst = 4; es_val = 7;
    #1;
    checks++; if (o_rj !== 32'd7 || o_rkd !== 32'd7) begin errors++; $display("FAIL fwd_es: got %0d/%0d want 7/7", o_rj, o_rkd); end
    checks++; if (o_alu !== 12'h001 || o_dest !== 5'd3 || o_gr_we !== 1'b1) begin errors++; $display("FAIL fwd_decode: alu %h dest %0d we %b want 001 3 1", o_alu, o_dest, o_gr_we); end
    checks++; if (ds_to_es_valid !== 1'b1) begin errors++; $display("FAIL fwd_valid: got %b want 1", ds_to_es_valid); end
    es_v = 0; #1;
    checks++; if (o_rj !== 32'd6) begin errors++; $display("FAIL fwd_ms: got %0d want 6", o_rj); end
    ms_v = 0; #1;
    checks++; if (o_rj !== 32'd5) begin errors++; $display("FAIL fwd_rf: got %0d want 5", o_rj); end
    rf_we = 1; rf_waddr = 4; rf_wdata = 9; #1;
    checks++; if (o_rkd !== 32'd9) begin errors++; $display("FAIL fwd_wb_same_cycle: got %0d want 9", o_rkd); end
    clear_fwd();
    drain();
  endtask

  task automatic test_load_use();
    es_v = 1; es_ld = 1; es_we = 1; es_dst = 5; es_val = 32'hDEADBEEF;
    issue(32'h028004A6, 32'h1C000020, 1'b0);
    checks++; if ({ds_allowin, ds_to_es_valid} !== 2'b00) begin errors++; $display("FAIL load_use_stall: allowin/valid %b want 00", {ds_allowin, ds_to_es_valid}); end
    @(posedge clk); #1;
    checks++; if ({ds_allowin, ds_to_es_valid} !== 2'b00) begin errors++; $display("FAIL load_use_hold: allowin/valid %b want 00", {ds_allowin, ds_to_es_valid}); end
    es_v = 0; ms_v = 1; ms_we = 1; ms_dst = 5; ms_val = 32'h12345678; #1;
    checks++; if ({ds_allowin, ds_to_es_valid} !== 2'b11) begin errors++; $display("FAIL load_use_release: allowin/valid %b want 11", {ds_allowin, ds_to_es_valid}); end
    checks++; if (o_rj !== 32'h12345678 || o_imm !== 32'd1 || o_pc !== 32'h1C000020) begin errors++; $display("FAIL load_use_value: rj %h imm %h pc %h want 12345678 1 1c000020", o_rj, o_imm, o_pc); end
    clear_fwd();
    drain();
  endtask

  task automatic test_beq();
    wb_write(5'd1, 32'hABCD);
    wb_write(5'd2, 32'hABCD);
    issue(32'h58002022, 32'h1C000010, 1'b0);
    checks++; if (br_collect !== {1'b1, 32'h1C000030}) begin errors++; $display("FAIL beq_taken: got %h want 11c000030", br_collect); end
    fs_to_ds_valid = 1; fs_inst = 32'h00101083; fs_pc = 32'h1C000014; fs_adef = 0;
    @(posedge clk); #1;
    fs_to_ds_valid = 0;
    checks++; if (ds_to_es_valid !== 1'b0) begin errors++; $display("FAIL beq_squash: got %b want 0", ds_to_es_valid); end
  endtask

  task automatic test_jirl();
    wb_write(5'd2, 32'h1C000100);
    issue(32'h4C000041, 32'h1C000040, 1'b0);
    checks++; if (br_collect !== {1'b1, 32'h1C000100}) begin errors++; $display("FAIL jirl_target: got %h want 11c000100", br_collect); end
    checks++; if ({o_dest, o_gr_we, o_src1_pc} !== {5'd1, 1'b1, 1'b1} || o_imm !== 32'd4 || o_alu !== 12'h001) begin errors++; $display("FAIL jirl_link: dest %0d we %b pc %b imm %h alu %h want 1 1 1 4 001", o_dest, o_gr_we, o_src1_pc, o_imm, o_alu); end
    drain();
  endtask

  task automatic test_illegal();
    issue(32'hFFFFFFFF, 32'h1C000050, 1'b0);
    checks++; if ({o_ine, o_gr_we, br_collect[32]} !== 3'b100) begin errors++; $display("FAIL illegal_ine: ine/we/br %b want 100", {o_ine, o_gr_we, br_collect[32]}); end
    drain();
    wb_write(5'd1, 32'd7);
    issue(32'h5C002020, 32'h1C000060, 1'b1);
    checks++; if ({o_adef, br_collect[32]} !== 2'b10) begin errors++; $display("FAIL adef_nobranch: adef/br %b want 10", {o_adef, br_collect[32]}); end
    drain();
  endtask

  task automatic test_reset_backpressure();
    issue(32'h50004000, 32'h1C000080, 1'b0);
    es_allowin = 0; #1;
    checks++; if (br_collect !== {1'b1, 32'h1C0000C0} || ds_allowin !== 1'b0) begin errors++; $display("FAIL bp_branch: br %h allowin %b want 11c0000c0 0", br_collect, ds_allowin); end
    @(posedge clk); #1;
    checks++; if (br_collect[32] !== 1'b1 || ds_to_es_valid !== 1'b1) begin errors++; $display("FAIL bp_hold: br %b valid %b want 1 1", br_collect[32], ds_to_es_valid); end
    #2 reset = 1; #1;
    checks++; if (br_collect !== 33'd0 || ds_to_es_valid !== 1'b0 || ds_allowin !== 1'b1) begin errors++; $display("FAIL bp_reset: br %h valid %b allowin %b want 0 0 1", br_collect, ds_to_es_valid, ds_allowin); end
    @(posedge clk); #1;
    reset = 0; es_allowin = 1;
    for (int i = 0; i < 32; i++) regs[i] = 0;
    issue(32'h00101083, 32'h1C000090, 1'b0);
    checks++; if (o_rj !== 32'd0) begin errors++; $display("FAIL reset_regfile: got %h want 0", o_rj); end
    drain();
  endtask

  function automatic logic [31:0] opnd(input logic [4:0] r);
    if (r == 0) return 32'd0;
    if (es_v && es_we && es_dst == r) return es_val;
    if (ms_v && ms_we && ms_dst == r) return ms_val;
    if (rf_we && rf_waddr == r) return rf_wdata;
    return regs[r];
  endfunction

  task automatic model(input mnem_t m, input logic [31:0] inst, input logic [31:0] pc,
                       input logic adef, output logic stall, output logic [151:0] bus,
                       output logic [32:0] br);
    logic [4:0]  rd, rj, rkr, dest;
    logic [31:0] vj, vk, imm, tgt, si12, offs16, offs26;
    logic [11:0] alu;
    logic        s1, s2, mwe, rfm, ine, cond, ur_j, ur_k, taken;
    int          ai;
    rd = inst[4:0]; rj = inst[9:5];
    rkr = (m == M_ST || m == M_BEQ || m == M_BNE) ? rd : inst[14:10];
    si12   = 32'($signed(inst[21:10]));
    offs16 = 32'($signed({inst[25:10], 2'b00}));
    offs26 = 32'($signed({inst[9:0], inst[25:10], 2'b00}));
    vj = opnd(rj); vk = opnd(rkr);
    ai = -1; imm = 0; s1 = 0; s2 = 0; dest = 0; mwe = 0; rfm = 0; ine = 0; cond = 0; tgt = 0;
    case (m)
      M_ADD:   begin ai = 0;  dest = rd; end
      M_SUB:   begin ai = 1;  dest = rd; end
      M_SLT:   begin ai = 2;  dest = rd; end
      M_SLTU:  begin ai = 3;  dest = rd; end
      M_AND:   begin ai = 4;  dest = rd; end
      M_NOR:   begin ai = 5;  dest = rd; end
      M_OR:    begin ai = 6;  dest = rd; end
      M_XOR:   begin ai = 7;  dest = rd; end
      M_SLLI:  begin ai = 8;  dest = rd; s2 = 1; imm = {27'd0, inst[14:10]}; end
      M_SRLI:  begin ai = 9;  dest = rd; s2 = 1; imm = {27'd0, inst[14:10]}; end
      M_SRAI:  begin ai = 10; dest = rd; s2 = 1; imm = {27'd0, inst[14:10]}; end
      M_ADDI:  begin ai = 0;  dest = rd; s2 = 1; imm = si12; end
      M_LD:    begin ai = 0;  dest = rd; s2 = 1; imm = si12; rfm = 1; end
      M_ST:    begin ai = 0;  s2 = 1; imm = si12; mwe = 1; end
      M_LU12I: begin ai = 11; dest = rd; s2 = 1; imm = {inst[24:5], 12'd0}; end
      M_JIRL:  begin ai = 0;  dest = rd; s1 = 1; s2 = 1; imm = 4; cond = 1; tgt = vj + offs16; end
      M_BL:    begin ai = 0;  dest = 1;  s1 = 1; s2 = 1; imm = 4; cond = 1; tgt = pc + offs26; end
      M_B:     begin cond = 1; tgt = pc + offs26; end
      M_BEQ:   begin cond = (vj == vk); tgt = pc + offs16; end
      M_BNE:   begin cond = (vj != vk); tgt = pc + offs16; end
      default: ine = 1;
    endcase
    alu  = (ai >= 0) ? 12'(1 << ai) : 12'd0;
    ur_j = !(m inside {M_LU12I, M_B, M_BL, M_ILL});
    ur_k = (m inside {[M_ADD:M_XOR], M_ST, M_BEQ, M_BNE});
    stall = es_v && es_ld && es_we && (es_dst != 0) &&
            ((ur_j && es_dst == rj) || (ur_k && es_dst == rkr));
    taken = !stall && !adef && cond;
    br  = taken ? {1'b1, tgt} : 33'd0;
    bus = {alu, vj, vk, imm, s1, s2, dest, (dest != 0), mwe, rfm, adef, ine, pc};
  endtask

  task automatic test_random();
    mnem_t        m;
    logic [31:0]  inst, pc;
    logic         adef, stall;
    logic [151:0] exp_bus;
    logic [32:0]  exp_br;
    logic [4:0]   rd, rj, rk;
    for (int it = 0; it < 400; it++) begin
      m  = mnem_t'($urandom_range(0, 20));
      rd = 5'($urandom_range(0, 7)); rj = 5'($urandom_range(0, 7)); rk = 5'($urandom_range(0, 7));
      inst = $urandom;
      case (m)
        M_ADD:  inst = {17'h20, rk, rj, rd};
        M_SUB:  inst = {17'h22, rk, rj, rd};
        M_SLT:  inst = {17'h24, rk, rj, rd};
        M_SLTU: inst = {17'h25, rk, rj, rd};
        M_NOR:  inst = {17'h28, rk, rj, rd};
        M_AND:  inst = {17'h29, rk, rj, rd};
        M_OR:   inst = {17'h2A, rk, rj, rd};
        M_XOR:  inst = {17'h2B, rk, rj, rd};
        M_SLLI: inst = {17'h81, inst[14:10], rj, rd};
        M_SRLI: inst = {17'h89, inst[14:10], rj, rd};
        M_SRAI: inst = {17'h91, inst[14:10], rj, rd};
        M_ADDI: inst = {10'h0A, inst[21:10], rj, rd};
        M_LD:   inst = {10'hA2, inst[21:10], rj, rd};
        M_ST:   inst = {10'hA6, inst[21:10], rj, rd};
        M_LU12I:inst = {7'h0A, inst[24:5], rd};
        M_JIRL: inst = {6'h13, inst[25:10], rj, rd};
        M_B:    inst = {6'h14, inst[25:0]};
        M_BL:   inst = {6'h15, inst[25:0]};
        M_BEQ:  inst = {6'h16, inst[25:10], rj, rd};
        M_BNE:  inst = {6'h17, inst[25:10], rj, rd};
        default: inst = {6'h3F, inst[25:0]};
      endcase
      pc   = $urandom & 32'hFFFF_FFFC;
      adef = ($urandom_range(0, 9) == 0);
      issue(inst, pc, adef);
      es_v = 1'($urandom_range(0, 1)); es_ld = ($urandom_range(0, 3) == 0); es_we = 1'($urandom_range(0, 1));
      es_dst = 5'($urandom_range(0, 7)); es_val = $urandom;
      ms_v = 1'($urandom_range(0, 1)); ms_we = 1'($urandom_range(0, 1));
      ms_dst = 5'($urandom_range(0, 7)); ms_val = $urandom;
      rf_we = 1'($urandom_range(0, 1)); rf_waddr = 5'($urandom_range(0, 7)); rf_wdata = $urandom;
      #1;
      model(m, inst, pc, adef, stall, exp_bus, exp_br);
      if (stall) begin
        checks++;
        if ({ds_allowin, ds_to_es_valid, br_collect} !== {2'b00, 33'd0}) begin
          errors++; $display("FAIL rand_stall it=%0d inst=%h: allowin %b valid %b br %h want 0 0 0", it, inst, ds_allowin, ds_to_es_valid, br_collect);
        end
        es_v = 0;
      end else begin
        checks++;
        if (ds_to_es_bus !== exp_bus) begin
          errors++; $display("FAIL rand_bus it=%0d inst=%h: got %h want %h", it, inst, ds_to_es_bus, exp_bus);
        end
        checks++;
        if (br_collect !== exp_br || {ds_allowin, ds_to_es_valid} !== 2'b11) begin
          errors++; $display("FAIL rand_br it=%0d inst=%h: br %h hs %b want %h 11", it, inst, br_collect, {ds_allowin, ds_to_es_valid}, exp_br);
        end
      end
      drain();
      if (rf_we && rf_waddr != 0) regs[rf_waddr] = rf_wdata;
      clear_fwd();
    end
  endtask

  initial begin
    test_reset();
    test_fwd_priority();
    test_load_use();
    test_beq();
    test_jirl();
    test_illegal();
    test_reset_backpressure();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
